// File: rtl/hiscore_pkg.sv
// Shared definitions for the high-score RAM arbiter: FSM state encoding,
// default bus widths and the settle-counter sizing.
package hiscore_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;

    // Largest supported SETTLE value; the settle counter is sized for it.
    localparam int SETTLE_MAX = 15;
    localparam int CNT_W      = $clog2(SETTLE_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RDWAIT = 3'd3,
        ST_DONE   = 3'd4
    } hs_state_t;

    // States in which the arbiter, not the CPU, drives the RAM port.
    function automatic logic owns_bus(input hs_state_t s);
        return (s == ST_SETTLE) || (s == ST_ACCESS) || (s == ST_RDWAIT);
    endfunction

endpackage

// File: rtl/hiscore_port_mux.sv
// Combinational RAM port select between the CPU and the high-score arbiter.
module hiscore_port_mux #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              sel_arb,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] arb_addr,
    input  logic [DATA_W-1:0] arb_wdata,
    input  logic              arb_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we
);

    // While the arbiter owns the port the CPU's write strobe is dropped entirely.
    always_comb begin
        ram_addr  = sel_arb ? arb_addr  : cpu_addr;
        ram_wdata = sel_arb ? arb_wdata : cpu_wdata;
        ram_we    = sel_arb ? arb_we    : cpu_we;
    end

endmodule

// File: rtl/hiscore_ram_arb.sv
// Arbiter between the game CPU and the high-score engine for the single-port
// work RAM. Pauses the CPU, waits SETTLE cycles, performs one word access and
// acknowledges it. Optional macro HS_BURST_EN: a request pending in DONE goes
// straight to ACCESS with the CPU kept paused.
module hiscore_ram_arb
    import hiscore_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic              cpu_pause,
    input  logic              hs_req,
    input  logic              hs_we,
    input  logic [ADDR_W-1:0] hs_addr,
    input  logic [DATA_W-1:0] hs_wdata,
    output logic              hs_ack,
    output logic [DATA_W-1:0] hs_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              conflict
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    hs_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pause_q, pause_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              conflict_q, conflict_d;

    logic              sel_arb;
    logic              arb_we;

    // Next-state logic: request capture, settle countdown, access sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pause_d    = pause_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        conflict_d = conflict_q | (cpu_we & owns_bus(state_q));

        case (state_q)
            ST_IDLE: begin
                if (hs_req) begin
                    addr_d  = hs_addr;
                    wdata_d = hs_wdata;
                    we_d    = hs_we;
                    pause_d = 1'b1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                state_d = we_q ? ST_DONE : ST_RDWAIT;
            end
            ST_RDWAIT: begin
                rdata_d = ram_rdata;
                state_d = ST_DONE;
            end
            ST_DONE: begin
`ifdef HS_BURST_EN
                // Back-to-back request: keep the CPU halted and skip settling.
                if (hs_req) begin
                    addr_d  = hs_addr;
                    wdata_d = hs_wdata;
                    we_d    = hs_we;
                    state_d = ST_ACCESS;
                end else begin
                    pause_d = 1'b0;
                    state_d = ST_IDLE;
                end
`else
                pause_d = 1'b0;
                state_d = ST_IDLE;
`endif
            end
            default: begin
                pause_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pause_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pause_q    <= pause_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            rdata_q    <= rdata_d;
            conflict_q <= conflict_d;
        end
    end

    // Output decode: the write strobe exists only in ACCESS of a write.
    always_comb begin
        sel_arb   = owns_bus(state_q);
        arb_we    = (state_q == ST_ACCESS) && we_q;
        hs_ack    = (state_q == ST_DONE);
        hs_rdata  = rdata_q;
        cpu_pause = pause_q;
        conflict  = conflict_q;
    end

    hiscore_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .sel_arb   (sel_arb),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .arb_addr  (addr_q),
        .arb_wdata (wdata_q),
        .arb_we    (arb_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we)
    );

endmodule

// File: tb/tb_hiscore_ram_arb.sv
// Directed bench for hiscore_ram_arb with a behavioural 1 KiB synchronous RAM.
module tb_hiscore_ram_arb;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int ST = 2;

`ifdef HS_BURST_EN
    localparam int GAP  = 2;
    localparam int LOWS = 0;
`else
    localparam int GAP  = ST + 3;
    localparam int LOWS = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic          cpu_pause;
    logic          hs_req;
    logic          hs_we;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_wdata;
    logic          hs_ack;
    logic [DW-1:0] hs_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;
    logic          conflict;

    logic [DW-1:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hiscore_ram_arb #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .SETTLE (ST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_pause (cpu_pause),
        .hs_req    (hs_req),
        .hs_we     (hs_we),
        .hs_addr   (hs_addr),
        .hs_wdata  (hs_wdata),
        .hs_ack    (hs_ack),
        .hs_rdata  (hs_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .conflict  (conflict)
    );

    // Synchronous single-port RAM: read data one cycle after the address.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One high-score transaction; cycle 0 is the cycle hs_req is raised.
    // inj >= 1 drives a CPU write to 0x100 during that cycle.
    task automatic run_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int inj,
                           output int ack_c, output int rise_c, output int we_cnt,
                           output logic [AW-1:0] we_a, output logic [DW-1:0] rd,
                           output logic inj_we, output logic pause_after, output logic ack_after);
        ack_c  = -1;
        rise_c = -1;
        we_cnt = 0;
        we_a   = '0;
        rd     = '0;
        inj_we = 1'bx;
        hs_we = we; hs_addr = a; hs_wdata = d; hs_req = 1'b1;
        for (int c = 1; c <= 30 && ack_c < 0; c++) begin
            tick;
            if (c == inj) begin
                cpu_addr = 10'h100; cpu_wdata = 8'hEE; cpu_we = 1'b1;
                #1 inj_we = ram_we;
            end else begin
                cpu_we = 1'b0;
            end
            if (cpu_pause && rise_c < 0) rise_c = c;
            if (ram_we) begin
                we_cnt++;
                we_a = ram_addr;
            end
            if (hs_ack) begin
                ack_c  = c;
                rd     = hs_rdata;
                hs_req = 1'b0;
            end
        end
        cpu_we = 1'b0;
        tick;
        pause_after = cpu_pause;
        ack_after   = hs_ack;
        $display("txn we=%0b addr=%03h wdata=%02h ack_cycle=%0d pause_cycle=%0d rdata=%02h",
                 we, a, d, ack_c, rise_c, rd);
    endtask

    initial begin
        int            ack_c, rise_c, we_cnt, n, lows, acks_seen;
        int            acks [3];
        logic [AW-1:0] we_a;
        logic [DW-1:0] rd;
        logic          inj_we, p_after, a_after, seen_rise;
        logic [AW-1:0] va [4];
        logic [DW-1:0] vd [4];
        logic          vw [4];

        // Reset state: port in CPU position, everything else cleared.
        reset = 1'b1;
        hs_req = 1'b0; hs_we = 1'b0; hs_addr = '0; hs_wdata = '0;
        cpu_addr = 10'h3FF; cpu_wdata = 8'h00; cpu_we = 1'b1;
        tick;
        tick;
        check("rst_pause", cpu_pause, 1'b0);
        check("rst_ack", hs_ack, 1'b0);
        check("rst_rdata", hs_rdata, 8'h00);
        check("rst_conflict", conflict, 1'b0);
        check("rst_ram_we", ram_we, 1'b1);
        check("rst_ram_addr", ram_addr, 10'h3FF);
        cpu_we = 1'b0;
        tick;
        reset = 1'b0;
        tick;

        // CPU-only traffic; also preloads 0x00B and 0x100.
        va[0] = 10'h00B; vd[0] = 8'h10; vw[0] = 1'b1;
        va[1] = 10'h100; vd[1] = 8'h11; vw[1] = 1'b1;
        va[2] = 10'h200; vd[2] = 8'h33; vw[2] = 1'b0;
        va[3] = 10'h3FF; vd[3] = 8'hC3; vw[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = va[i]; cpu_wdata = vd[i]; cpu_we = vw[i];
            #1;
            check("cpu_ram_addr", ram_addr, va[i]);
            check("cpu_ram_wdata", ram_wdata, vd[i]);
            check("cpu_ram_we", ram_we, vw[i]);
            check("cpu_pause_low", cpu_pause, 1'b0);
            tick;
            $display("cpu addr=%03h wdata=%02h we=%0b", va[i], vd[i], vw[i]);
        end
        cpu_we = 1'b0;
        cpu_addr = 10'h000;

        // High-score write.
        check("wr_pause_c0", cpu_pause, 1'b0);
        run_txn(1'b1, 10'h023, 8'h5A, -1, ack_c, rise_c, we_cnt, we_a, rd, inj_we, p_after, a_after);
        check("wr_ack_cycle", ack_c, ST + 2);
        check("wr_pause_rise", rise_c, 1);
        check("wr_we_pulses", we_cnt, 1);
        check("wr_we_addr", we_a, 10'h023);
        check("wr_pause_after", p_after, 1'b0);
        check("wr_ack_after", a_after, 1'b0);
        check("wr_readback", mem[10'h023], 8'h5A);

        // High-score read of preloaded word.
        run_txn(1'b0, 10'h00B, 8'h00, -1, ack_c, rise_c, we_cnt, we_a, rd, inj_we, p_after, a_after);
        check("rd_ack_cycle", ack_c, ST + 3);
        check("rd_rdata", rd, 8'h10);
        check("rd_we_pulses", we_cnt, 0);
        check("rd_pause_rise", rise_c, 1);

        // CPU write during SETTLE is flagged and discarded.
        run_txn(1'b1, 10'h050, 8'h77, 1, ack_c, rise_c, we_cnt, we_a, rd, inj_we, p_after, a_after);
        check("cf_inj_ram_we", inj_we, 1'b0);
        check("cf_ack_cycle", ack_c, ST + 2);
        check("cf_conflict", conflict, 1'b1);
        check("cf_mem_100", mem[10'h100], 8'h11);
        check("cf_mem_050", mem[10'h050], 8'h77);
        check("cf_we_pulses", we_cnt, 1);

        // Reset while in RDWAIT (cycle SETTLE+2 of a read).
        hs_we = 1'b0; hs_addr = 10'h00B; hs_req = 1'b1;
        cpu_addr = 10'h155;
        for (int c = 1; c <= ST + 2; c++) tick;
        check("rs_pause_before", cpu_pause, 1'b1);
        reset = 1'b1;
        #1;
        check("rs_pause_now", cpu_pause, 1'b0);
        check("rs_ack_now", hs_ack, 1'b0);
        hs_req = 1'b0;
        tick;
        check("rs_pause_next", cpu_pause, 1'b0);
        check("rs_conflict", conflict, 1'b0);
        check("rs_rdata", hs_rdata, 8'h00);
        reset = 1'b0;
        acks_seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (hs_ack) acks_seen++;
        end
        check("rs_no_ack", acks_seen, 0);
        check("rs_port_cpu", ram_addr, 10'h155);
        $display("txn reset-in-rdwait acks_after=%0d", acks_seen);

        // Three back-to-back writes 0x3C0..0x3C2.
        cpu_addr = 10'h000;
        hs_we = 1'b1; hs_addr = 10'h3C0; hs_wdata = 8'hA0; hs_req = 1'b1;
        n = 0; lows = 0; seen_rise = 1'b0;
        for (int i = 0; i < 3; i++) acks[i] = -1;
        for (int c = 1; c <= 60 && n < 3; c++) begin
            tick;
            if (cpu_pause) seen_rise = 1'b1;
            else if (seen_rise) lows++;
            if (hs_ack) begin
                acks[n] = c;
                n++;
                if (n < 3) begin
                    hs_addr  = 10'h3C0 + 10'(n);
                    hs_wdata = 8'hA0 + 8'(n);
                end else begin
                    hs_req = 1'b0;
                end
            end
        end
        tick;
        check("bb_ack0", acks[0], ST + 2);
        check("bb_ack1", acks[1], ST + 2 + GAP);
        check("bb_ack2", acks[2], ST + 2 + 2 * GAP);
        check("bb_pause_lows", lows, LOWS);
        check("bb_mem0", mem[10'h3C0], 8'hA0);
        check("bb_mem1", mem[10'h3C1], 8'hA1);
        check("bb_mem2", mem[10'h3C2], 8'hA2);
        check("bb_pause_end", cpu_pause, 1'b0);
        $display("txn burst acks=%0d,%0d,%0d pause_low_cycles=%0d", acks[0], acks[1], acks[2], lows);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
